alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, two-stage pipelined ALU; successor to the 4-bit-opcode combinational ALU.
//  Sits between the decode/issue stage and the writeback stage.
//  Valid/ready handshake on both sides, registered flags, tag passthrough, one result per cycle.
// PARAMETERS
//  WIDTH  32  operand/result width in bits (>=4)
//  TAG_W  4   width of the opaque tag carried alongside each op (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands/op/tag valid
//  in_ready   out  1      stage 1 can accept this cycle
//  in_op      in   4      opcode (see BEHAVIOUR)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_tag     in   TAG_W  tag, returned unchanged with the result
//  out_valid  out  1      result/flags/tag valid
//  out_ready  in   1      downstream accepts this cycle
//  out_res    out  WIDTH  result
//  out_flags  out  4      {N,Z,C,V}
//  out_err    out  1      illegal opcode; result forced to 0
//  out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  - Reset (rst_n=0, async): both stage valids, out_res, out_flags, out_err and out_tag are all 0. in_ready=1 from the first cycle after release.
//  - Pipeline: S1 registers {op,a,b,tag}. S2 computes and registers {res,flags,err,tag}. Latency is exactly 2 clk from accept to out_valid.
//  - Transfer occurs when valid&&ready on the same edge. Throughput is 1/cycle with out_ready held high.
//  - s2_free = !s2_valid || out_ready. S1 advances when s2_free.
//    in_ready = !s1_valid || s2_free (combinational, no input-to-output comb path other than out_ready).
//  - Back-pressure: when out_ready=0, S2 holds. S1 fills, then in_ready drops.
//    Held outputs must not change while out_valid && !out_ready.
//  - Ops (mod 2^WIDTH):
//    0000 A+B; 0001 A-B; 0010 A; 0011 A+~B (sub with borrow);
//    0100 A+1; 0101 A-1; 0110 A+B+1; 0111 A&B;
//    1000 A|B; 1001 A^B; 1010 ~A; 1011 A<<1.
//    1100-1111: illegal, res=0, flags=0100 (Z only), err=1.
//  - Arithmetic is done at WIDTH+1 bits.
//    C = bit WIDTH of the sum. Subtraction ops are computed as A+~B(+1), so C=1 means no borrow.
//    A-1 is computed as A+all-ones.
//    V = signed overflow of the add form: operands of equal sign, result of differing sign.
//  - Logic/move ops: C=0, V=0. Shift op 1011: C = A[WIDTH-1], V=0.
//  - N = res[WIDTH-1]. Z = (res==0).
//  - Wrap: all results wrap modulo 2^WIDTH; no exceptions are raised.
//  - Simultaneous events: accept into S1 and drain from S2 may happen on the same edge.
//  - Reset mid-operation: in-flight ops are discarded and never appear at the output.
//  - in_* are sampled only on accept; values while in_valid=0 are don't-care.
// CONFIGURATION
//  - ALU_SAT_EN defined: ops 0000/0001/0110 saturate to the signed range on V=1.
//    Positive overflow gives 0111..1; negative overflow gives 1000..0.
//    V is still reported as 1. C is computed from the unsaturated sum.
//  - ALU_SAT_EN undefined: these ops wrap as listed above. No extra logic.
// TESTING (WIDTH=8, TAG_W=4)
//  - Reset/idle: rst_n=0 then 1, no stimulus -> out_valid=0, in_ready=1, out_res=0x00, out_flags=0.
//  - Add carry/zero: op=0000 A=0xFF B=0x01 tag=3 -> 2 clk later res=0x00, {N,Z,C,V}=0110, tag=3.
//  - Sub/overflow: op=0001 A=0x80 B=0x01 -> res=0x7F, flags=0011.
//    With ALU_SAT_EN the same stimulus gives res=0x80, flags=1011.
//  - Streaming + backpressure: 8 back-to-back ops with out_ready=0 for cycles 3-6.
//    Expect in_ready=0 once both stages are full, then all 8 results in order with matching tags: no loss, no duplicates.
//  - Illegal/shift: op=1110 -> err=1, res=0x00, flags=0100. op=1011 A=0x81 -> res=0x02, flags=0010.
//  - Async reset mid-flight: assert rst_n with 2 ops in the pipe -> outputs are 0 immediately.
//    After release no stale result appears.

Source files
------------

// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: issue-side operands/op/tag in, writeback-side result/flags/tag out.
// master drives operands and out_ready; slave (the ALU) drives in_ready and the result side.
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic [3:0]       out_flags;
  logic             out_err;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_flags, out_err, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_flags, out_err, out_tag
  );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU, result 2 clk after accept, one per cycle; S2 holds and S1 fills under back-pressure.
// Optional macro ALU_SAT_EN: ops 0000/0001/0110 saturate to the signed range on overflow.
module alu_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input logic       clk,
  input logic       rst_n,
  alu_pipe_if.slave bus
);
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_SBB = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4;
  localparam logic [3:0] OP_DEC = 4'h5;
  localparam logic [3:0] OP_ADC = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_NOT = 4'hA;
  localparam logic [3:0] OP_SHL = 4'hB;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       flags;
    logic             err;
    logic [TAG_W-1:0] tag;
  } s2_t;

  s1_t  s1;
  s2_t  s2;
  s2_t  s2_next;
  logic s1_valid;
  logic s2_valid;
  logic s2_free;
  logic in_ready;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  logic             add_v;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;
  logic             err;

  assign s2_free  = !s2_valid || bus.out_ready;
  assign in_ready = !s1_valid || s2_free;

  // Every arithmetic op is one adder: A + y + cin, with subtraction as A + ~B (+1).
  assign add_x = s1.a;

  always_comb begin
    add_y   = '0;
    add_cin = 1'b0;
    case (s1.op)
      OP_ADD: add_y = s1.b;
      OP_SUB: begin
        add_y   = ~s1.b;
        add_cin = 1'b1;
      end
      OP_SBB: add_y = ~s1.b;
      OP_INC: add_cin = 1'b1;
      OP_DEC: add_y = '1;
      OP_ADC: begin
        add_y   = s1.b;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
  assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) && (sum[WIDTH-1] != add_x[WIDTH-1]);

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    err = 1'b0;
    case (s1.op)
      OP_ADD, OP_SUB, OP_SBB, OP_INC, OP_DEC, OP_ADC: begin
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = add_v;
      end
      OP_MOV: res = s1.a;
      OP_AND: res = s1.a & s1.b;
      OP_OR:  res = s1.a | s1.b;
      OP_XOR: res = s1.a ^ s1.b;
      OP_NOT: res = ~s1.a;
      OP_SHL: begin
        res = {s1.a[WIDTH-2:0], 1'b0};
        c   = s1.a[WIDTH-1];
      end
      default: err = 1'b1;
    endcase
`ifdef ALU_SAT_EN
    // Operand sign picks the rail; C and V still describe the unsaturated sum.
    if (v && (s1.op == OP_ADD || s1.op == OP_SUB || s1.op == OP_ADC)) begin
      res = add_x[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_comb begin
    s2_next       = '0;
    s2_next.res   = res;
    s2_next.flags = {res[WIDTH-1], (res == '0), c, v};
    s2_next.err   = err;
    s2_next.tag   = s1.tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s2_valid <= 1'b0;
      s2       <= '0;
    end else begin
      if (s2_free) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2 <= s2_next;
        end
      end
      if (in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1.op  <= bus.in_op;
          s1.a   <= bus.in_a;
          s1.b   <= bus.in_b;
          s1.tag <= bus.in_tag;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.out_res   = s2.res;
  assign bus.out_flags = s2.flags;
  assign bus.out_err   = s2.err;
  assign bus.out_tag   = s2.tag;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=8, TAG_W=4: integer-arithmetic reference model plus directed vectors.
module tb_alu_pipe;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  alu_pipe_if #(.WIDTH(8), .TAG_W(4)) bus ();

  alu_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] tag;
    logic [7:0] res;
    logic [3:0] flags;
    logic       err;
  } exp_t;

`ifdef ALU_SAT_EN
  localparam logic [7:0] SUB_OV_RES   = 8'h80;
  localparam logic [3:0] SUB_OV_FLAGS = 4'b1011;
`else
  localparam logic [7:0] SUB_OV_RES   = 8'h7F;
  localparam logic [3:0] SUB_OV_FLAGS = 4'b0011;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  bit   saw_full = 0;
  exp_t q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int sgn8(input logic [7:0] x);
    return x[7] ? int'(x) - 256 : int'(x);
  endfunction

  // Reference: unsigned sum for result/carry, true signed value for overflow.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   ua = int'(a);
    int   ub = int'(b);
    int   sa = sgn8(a);
    int   sb = sgn8(b);
    int   u  = 0;
    int   s  = 0;
    bit   arith = 1'b1;
    bit   c = 1'b0;
    bit   v = 1'b0;
    logic [7:0] r = 8'h00;
    logic err = 1'b0;
    case (op)
      4'h0: begin u = ua + ub;             s = sa + sb; end
      4'h1: begin u = ua + (255 - ub) + 1; s = sa - sb; end
      4'h3: begin u = ua + (255 - ub);     s = sa + sgn8(~b); end
      4'h4: begin u = ua + 1;              s = sa + 1; end
      4'h5: begin u = ua + 255;            s = sa - 1; end
      4'h6: begin u = ua + ub + 1;         s = sa + sb + 1; end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      r = u[7:0];
      c = (u > 255);
      v = (s > 127) || (s < -128);
`ifdef ALU_SAT_EN
      if (v && (op == 4'h0 || op == 4'h1 || op == 4'h6)) r = (s > 127) ? 8'h7F : 8'h80;
`endif
    end else begin
      case (op)
        4'h2: r = a;
        4'h7: r = a & b;
        4'h8: r = a | b;
        4'h9: r = a ^ b;
        4'hA: r = ~a;
        4'hB: begin r = a << 1; c = a[7]; end
        default: err = 1'b1;
      endcase
    end
    e.tag   = 4'h0;
    e.res   = r;
    e.flags = {r[7], (r == 8'h00), c, v};
    e.err   = err;
    return e;
  endfunction

  // Compare process: scoreboard on every transfer, hold check on every stalled cycle.
  initial begin
    bit stalled = 0;
    logic [17:0] prev = '0;
    exp_t e;
    exp_t m;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 0;
        continue;
      end
      if (stalled) chk("hold_stable", {14'h0, bus.out_valid, bus.out_res, bus.out_flags, bus.out_err, bus.out_tag}, {14'h0, prev});
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out", {24'h0, bus.out_res}, 32'hDEAD);
        end else begin
          e = q.pop_front();
          chk("sb_res", {24'h0, bus.out_res}, {24'h0, e.res});
          chk("sb_flags", {28'h0, bus.out_flags}, {28'h0, e.flags});
          chk("sb_err", {31'h0, bus.out_err}, {31'h0, e.err});
          chk("sb_tag", {28'h0, bus.out_tag}, {28'h0, e.tag});
          n_out++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        m = model(bus.in_op, bus.in_a, bus.in_b);
        m.tag = bus.in_tag;
        q.push_back(m);
      end
      if (bus.in_valid && !bus.in_ready) saw_full = 1;
      stalled = bus.out_valid && !bus.out_ready;
      prev = {bus.out_valid, bus.out_res, bus.out_flags, bus.out_err, bus.out_tag};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tag;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 50);
    if (!bus.in_ready) chk("send_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic one(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [3:0] tag, input logic [7:0] r, input logic [3:0] f, input logic err);
    send(op, a, b, tag);
    chk({name, "_lat1_valid"}, {31'h0, bus.out_valid}, 32'h0);
    @(posedge clk);
    #1;
    chk({name, "_lat2_valid"}, {31'h0, bus.out_valid}, 32'h1);
    chk({name, "_res"}, {24'h0, bus.out_res}, {24'h0, r});
    chk({name, "_flags"}, {28'h0, bus.out_flags}, {28'h0, f});
    chk({name, "_err"}, {31'h0, bus.out_err}, {31'h0, err});
    chk({name, "_tag"}, {28'h0, bus.out_tag}, {28'h0, tag});
  endtask

  logic [3:0] s_op [8] = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
  logic [7:0] s_a  [8] = '{8'h5A, 8'h10, 8'h7F, 8'h00, 8'h7F, 8'hF0, 8'h0F, 8'hAA};
  logic [7:0] s_b  [8] = '{8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hF0, 8'hAA};

  initial begin
    exp_t m;
    int   n0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'h0;
    bus.in_a      = 8'h00;
    bus.in_b      = 8'h00;
    bus.in_tag    = 4'h0;
    bus.out_ready = 1'b1;

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_out_res", {24'h0, bus.out_res}, 32'h0);
    chk("rst_out_flags", {28'h0, bus.out_flags}, 32'h0);
    chk("rst_out_err_tag", {27'h0, bus.out_err, bus.out_tag}, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("idle_out_valid", {31'h0, bus.out_valid}, 32'h0);

    // Literal pins on the reference model itself.
    m = model(4'h0, 8'hFF, 8'h01);
    chk("pin_add", {m.res, m.flags, m.err}, {8'h00, 4'b0110, 1'b0});
    m = model(4'h1, 8'h80, 8'h01);
    chk("pin_sub_ov", {m.res, m.flags, m.err}, {SUB_OV_RES, SUB_OV_FLAGS, 1'b0});
    m = model(4'hE, 8'h12, 8'h34);
    chk("pin_illegal", {m.res, m.flags, m.err}, {8'h00, 4'b0100, 1'b1});
    m = model(4'hB, 8'h81, 8'h00);
    chk("pin_shl", {m.res, m.flags, m.err}, {8'h02, 4'b0010, 1'b0});
    m = model(4'h5, 8'h00, 8'h00);
    chk("pin_dec", {m.res, m.flags, m.err}, {8'hFF, 4'b1000, 1'b0});
    m = model(4'h4, 8'h7F, 8'h00);
    chk("pin_inc_ov", {m.res, m.flags, m.err}, {8'h80, 4'b1001, 1'b0});

    one("add_carry", 4'h0, 8'hFF, 8'h01, 4'h3, 8'h00, 4'b0110, 1'b0);
    one("sub_ov",    4'h1, 8'h80, 8'h01, 4'h7, SUB_OV_RES, SUB_OV_FLAGS, 1'b0);
    one("illegal",   4'hE, 8'h55, 8'h66, 4'h9, 8'h00, 4'b0100, 1'b1);
    one("shl",       4'hB, 8'h81, 8'h00, 4'hC, 8'h02, 4'b0010, 1'b0);
    one("not",       4'hA, 8'h0F, 8'h00, 4'h1, 8'hF0, 4'b1000, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    n0 = n_out;
    saw_full = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(s_op[i], s_a[i], s_b[i], 4'(i + 8));
      end
      begin
        repeat (2) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("stream_drained", q.size(), 32'h0);
    chk("stream_count", n_out - n0, 32'd8);
    chk("stream_in_ready_dropped", {31'h0, saw_full}, 32'h1);

    send(4'h0, 8'h12, 8'h34, 4'h5);
    send(4'h9, 8'hF0, 8'h0F, 4'h6);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("midrst_out_res", {24'h0, bus.out_res}, 32'h0);
    chk("midrst_out_flags", {28'h0, bus.out_flags}, 32'h0);
    chk("midrst_out_err_tag", {27'h0, bus.out_err, bus.out_tag}, 32'h0);
    q.delete();
    n0 = n_out;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_stale", n_out - n0, 32'h0);
    chk("midrst_in_ready", {31'h0, bus.in_ready}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
